// File: rtl/cpuDefine.sv
// Shared CPU definitions: register-file FSM states and default geometry.
package cpuDefine;

  localparam int REG_NUM_DEF = 32;
  localparam int DATA_W_DEF  = 32;

  typedef enum logic {
    INIT,
    RUN
  } regfile_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: read ports, write ports, scoreboard allocation and status.
interface regfile_mp_if
  import cpuDefine::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int NUM_RD  = 4,
  parameter int NUM_WR  = 2
);
  localparam int ADDR_W = $clog2(REG_NUM);

  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_ready;
  logic [NUM_WR-1:0]             wr_en;
  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
  logic                          alloc_en;
  logic [ADDR_W-1:0]             alloc_addr;
  logic                          flush;
  logic                          init_done;
  logic [REG_NUM-1:0]            busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rd_data, rd_ready, init_done, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rd_data, rd_ready, init_done, busy_vec
  );

endinterface

// File: rtl/regfile_bypass_mux.sv
// Per-read-port forwarding: picks the highest-index write port matching the
// read address, else the stored array word.
module regfile_bypass_mux #(
  parameter int DATA_W = 32,
  parameter int NUM_WR = 2,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]             arr_word,
  output logic [DATA_W-1:0]             data,
  output logic                          hit
);

  // Ascending scan so the last (highest-index) match overrides earlier ones.
  always_comb begin
    data = arr_word;
    hit  = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && (wr_addr[i] == rd_addr)) begin
        data = wr_data[i];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, r0 hardwired to zero,
// busy-bit scoreboard and a post-reset clearing sweep.
module regfile_mp
  import cpuDefine::*;
#(
  parameter int  DATA_W  = DATA_W_DEF,
  parameter int  REG_NUM = REG_NUM_DEF,
  parameter int  NUM_RD  = 4,
  parameter int  NUM_WR  = 2,
  localparam int ADDR_W  = $clog2(REG_NUM)
) (
  input  logic             aclk,
  input  logic             areset,
  regfile_mp_if.slave      bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

  regfile_state_e      state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic [REG_NUM-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0]   rf_mem [REG_NUM];
  logic                run;

  assign run = (state_q == RUN);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == INIT) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == LAST_IDX) begin
        state_d = RUN;
      end
    end
  end

  // Flush beats everything; an alloc beats a same-cycle writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (bus.flush) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (bus.wr_en[i]) begin
            busy_d[bus.wr_addr[i]] = 1'b0;
          end
        end
        if (bus.alloc_en) begin
          busy_d[bus.alloc_addr] = 1'b1;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= INIT;
      clr_idx_q <= ADDR_W'(1);
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  // Storage has no reset; the sweep zeroes it. Later ports win on collisions.
  always_ff @(posedge aclk) begin
    if (!run) begin
      rf_mem[clr_idx_q] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wr_en[i] && (bus.wr_addr[i] != '0)) begin
          rf_mem[bus.wr_addr[i]] <= bus.wr_data[i];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [DATA_W-1:0] mux_data;
      logic              mux_hit;
      logic              is_r0;

      regfile_bypass_mux #(
        .DATA_W (DATA_W),
        .NUM_WR (NUM_WR),
        .ADDR_W (ADDR_W)
      ) u_bypass (
        .rd_addr  (bus.rd_addr[gi]),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .wr_data  (bus.wr_data),
        .arr_word (rf_mem[bus.rd_addr[gi]]),
        .data     (mux_data),
        .hit      (mux_hit)
      );

      assign is_r0             = (bus.rd_addr[gi] == '0);
      assign bus.rd_data[gi]   = (run && !is_r0) ? mux_data : '0;
      assign bus.rd_ready[gi]  = run && (is_r0 || mux_hit || !busy_q[bus.rd_addr[gi]]);
    end
  endgenerate

  assign bus.init_done = run;
  assign bus.busy_vec  = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus queues expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int RN = 32;
  localparam int NR = 4;
  localparam int NW = 2;

  logic aclk;
  logic areset;

  regfile_mp_if #(.DATA_W(DW), .REG_NUM(RN), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_mp #(.DATA_W(DW), .REG_NUM(RN), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  typedef struct {
    int          kind;   // 0 read port, 1 busy_vec, 2 init_done
    int          port;
    logic [31:0] val;
    logic        rdy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", n_checks);
    $fatal(1, "watchdog timeout");
  end

  task automatic exp_rd(input int p, input logic [31:0] d, input logic r, input string nm);
    exp_t e;
    e.kind = 0; e.port = p; e.val = d; e.rdy = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic exp_busy(input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = 1; e.port = 0; e.val = v; e.rdy = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic exp_init(input logic d, input string nm);
    exp_t e;
    e.kind = 2; e.port = 0; e.val = '0; e.rdy = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cycle();
    @(negedge aclk);
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;
    bus.flush      = 1'b0;
    bus.rd_addr    = '0;
  endtask

  always @(negedge aclk) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (e.kind)
        0: begin
          n_checks++;
          if (bus.rd_data[e.port] !== e.val) begin
            n_fail++;
            $display("FAIL %s: port%0d rd_data got %h expected %h", nm, e.port, bus.rd_data[e.port], e.val);
          end
          n_checks++;
          if (bus.rd_ready[e.port] !== e.rdy) begin
            n_fail++;
            $display("FAIL %s: port%0d rd_ready got %b expected %b", nm, e.port, bus.rd_ready[e.port], e.rdy);
          end
          $display("%0t %s: port%0d addr=%0d data=%h ready=%b", $time, nm, e.port,
                   bus.rd_addr[e.port], bus.rd_data[e.port], bus.rd_ready[e.port]);
        end
        1: begin
          n_checks++;
          if (bus.busy_vec !== e.val) begin
            n_fail++;
            $display("FAIL %s: busy_vec got %h expected %h", nm, bus.busy_vec, e.val);
          end
          $display("%0t %s: busy_vec=%h", $time, nm, bus.busy_vec);
        end
        default: begin
          n_checks++;
          if (bus.init_done !== e.rdy) begin
            n_fail++;
            $display("FAIL %s: init_done got %b expected %b", nm, bus.init_done, e.rdy);
          end
          $display("%0t %s: init_done=%b", $time, nm, bus.init_done);
        end
      endcase
    end
  end

  initial begin
    areset = 1'b1;
    idle();
    @(posedge aclk);
    #1;

    // Reset state
    exp_init(1'b0, "rst_init_done");
    exp_busy(32'h0, "rst_busy");
    exp_rd(0, 32'h0, 1'b0, "rst_rd_blocked");
    cycle();

    // Sweep length: init_done rises exactly 31 edges after release
    areset = 1'b0;
    repeat (30) cycle();
    exp_init(1'b0, "init_after_30_edges");
    exp_rd(1, 32'h0, 1'b0, "init_rd_blocked");
    cycle();
    exp_init(1'b1, "init_after_31_edges");

    for (int g = 0; g < RN / NR; g++) begin
      for (int p = 0; p < NR; p++) begin
        bus.rd_addr[p] = 5'(g * NR + p);
        exp_rd(p, 32'h0, 1'b1, $sformatf("sweep_r%0d", g * NR + p));
      end
      cycle();
    end

    // Dual write to same address: highest port wins, bypass then array
    idle();
    bus.wr_en      = 2'b11;
    bus.wr_addr[0] = 5'd5;  bus.wr_data[0] = 32'h0000AAAA;
    bus.wr_addr[1] = 5'd5;  bus.wr_data[1] = 32'h0000BBBB;
    bus.rd_addr[0] = 5'd5;
    exp_rd(0, 32'h0000BBBB, 1'b1, "dual_wr_bypass");
    cycle();
    idle();
    bus.rd_addr[0] = 5'd5;
    exp_rd(0, 32'h0000BBBB, 1'b1, "dual_wr_array");
    cycle();

    // Independent writes on both ports, four reads at once
    idle();
    bus.wr_en      = 2'b11;
    bus.wr_addr[0] = 5'd10; bus.wr_data[0] = 32'h000000A0;
    bus.wr_addr[1] = 5'd11; bus.wr_data[1] = 32'h000000B1;
    bus.rd_addr[0] = 5'd10; bus.rd_addr[1] = 5'd11; bus.rd_addr[2] = 5'd5; bus.rd_addr[3] = 5'd0;
    exp_rd(0, 32'h000000A0, 1'b1, "split_bypass_p0");
    exp_rd(1, 32'h000000B1, 1'b1, "split_bypass_p1");
    exp_rd(2, 32'h0000BBBB, 1'b1, "split_array_r5");
    exp_rd(3, 32'h0, 1'b1, "split_r0");
    cycle();
    idle();
    bus.rd_addr[0] = 5'd10; bus.rd_addr[1] = 5'd11;
    exp_rd(0, 32'h000000A0, 1'b1, "split_array_r10");
    exp_rd(1, 32'h000000B1, 1'b1, "split_array_r11");
    cycle();

    // Alloc 7, observe busy, then writeback clears it
    idle();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd7;
    bus.rd_addr[1] = 5'd7;
    exp_rd(1, 32'h0, 1'b1, "alloc7_same_cycle");
    exp_busy(32'h0, "alloc7_busy_before");
    cycle();
    idle();
    bus.rd_addr[1] = 5'd7;
    exp_rd(1, 32'h0, 1'b0, "busy7_not_ready");
    exp_busy(32'h0000_0080, "busy7_set");
    cycle();
    idle();
    bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd7; bus.wr_data[0] = 32'h00001234;
    bus.rd_addr[1] = 5'd7;
    exp_rd(1, 32'h00001234, 1'b1, "wb7_bypass_ready");
    exp_busy(32'h0000_0080, "wb7_busy_still_reg");
    cycle();
    idle();
    bus.rd_addr[1] = 5'd7;
    exp_rd(1, 32'h00001234, 1'b1, "wb7_array");
    exp_busy(32'h0, "busy7_cleared");
    cycle();

    // Alloc and write same register: alloc wins; then flush drops alloc 3
    idle();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9;
    bus.wr_en = 2'b10; bus.wr_addr[1] = 5'd9; bus.wr_data[1] = 32'h00000099;
    bus.rd_addr[2] = 5'd9;
    exp_rd(2, 32'h00000099, 1'b1, "alloc_wr9_bypass");
    cycle();
    idle();
    bus.flush = 1'b1; bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3;
    bus.rd_addr[2] = 5'd9;
    exp_rd(2, 32'h00000099, 1'b0, "busy9_not_ready");
    exp_busy(32'h0000_0200, "alloc_beats_clear9");
    cycle();
    idle();
    bus.rd_addr[2] = 5'd3;
    exp_rd(2, 32'h0, 1'b1, "flush_r3_ready");
    exp_busy(32'h0, "flush_cleared");
    cycle();

    // Register 0 ignores writes and allocs
    idle();
    bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd0; bus.wr_data[0] = 32'h0000FFFF;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd0;
    bus.rd_addr[3] = 5'd0;
    exp_rd(3, 32'h0, 1'b1, "r0_wr_same_cycle");
    cycle();
    idle();
    bus.rd_addr[3] = 5'd0;
    exp_rd(3, 32'h0, 1'b1, "r0_after_wr");
    exp_busy(32'h0, "r0_never_busy");
    cycle();

    // Mid-run reset: sweep restarts, writes/allocs during INIT ignored
    idle();
    bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd4; bus.wr_data[0] = 32'h00000055;
    cycle();
    idle();
    bus.rd_addr[0] = 5'd4;
    exp_rd(0, 32'h00000055, 1'b1, "r4_written");
    exp_init(1'b1, "run_before_reset");
    cycle();
    areset = 1'b1;
    exp_init(1'b0, "midrun_reset_init_done");
    exp_rd(0, 32'h0, 1'b0, "midrun_reset_rd_blocked");
    cycle();
    areset = 1'b0;
    for (int k = 0; k < RN - 1; k++) begin
      bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd4; bus.wr_data[0] = 32'h00000077;
      bus.alloc_en = 1'b1; bus.alloc_addr = 5'd4;
      bus.rd_addr[0] = 5'd4;
      if (k == 0 || k == 15 || k == RN - 2) begin
        exp_rd(0, 32'h0, 1'b0, $sformatf("init2_rd_k%0d", k));
        exp_init(1'b0, $sformatf("init2_done_k%0d", k));
      end
      cycle();
    end
    idle();
    bus.rd_addr[0] = 5'd4;
    bus.rd_addr[1] = 5'd10;
    exp_init(1'b1, "init2_done");
    exp_rd(0, 32'h0, 1'b1, "r4_swept");
    exp_rd(1, 32'h0, 1'b1, "r10_swept");
    exp_busy(32'h0, "init2_busy_clear");
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Multi-port general-purpose register file, the parametrised successor of the single-write, 3+2-read regfile. It provides NUM_RD read ports and NUM_WR write ports, with same-cycle write-to-read bypass and register 0 hardwired to zero. It adds a busy-bit scoreboard that issue uses to detect RAW hazards, and a post-reset clearing sequencer. It sits between decode/issue (reads, allocation) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits
REG_NUM, 32, number of architectural registers (power of two, ≥4)
NUM_RD, 4, read ports
NUM_WR, 2, write ports
ADDR_W, $clog2(REG_NUM), register index width (derived; not overridden)

Ports:
aclk  in  1  clock, all state updates on posedge
areset  in  1  asynchronous, active-high reset
rd_addr  in  [NUM_RD][ADDR_W]  read indices
rd_data  out  [NUM_RD][DATA_W]  read data (combinational)
rd_ready  out  [NUM_RD]  operand available: not busy, or bypassed this cycle
wr_en  in  [NUM_WR]  write strobes
wr_addr  in  [NUM_WR][ADDR_W]  write indices
wr_data  in  [NUM_WR][DATA_W]  write data
alloc_en  in  1  mark destination busy (instruction issued)
alloc_addr  in  ADDR_W  destination to mark busy
flush  in  1  clear all busy bits (pipeline flush)
init_done  out  1  high once the clearing sweep has completed
busy_vec  out  REG_NUM  scoreboard state, for debug/issue

Behaviour:
- FSM states: INIT, RUN.
- On areset: state=INIT, clr_idx=1, busy=0, init_done=0. Storage contents are undefined until swept.
- INIT: each posedge writes 0 to rf[clr_idx], then clr_idx++. The write at clr_idx==REG_NUM-1 moves the FSM to RUN. init_done=1 from the next cycle, which is exactly REG_NUM-1 clock edges after areset deasserts.
- During INIT:
  - wr_en, alloc_en and flush are ignored.
  - rd_data=0, rd_ready=0.
- areset asserted mid-operation (either state): immediately returns to INIT and the sweep restarts from index 1.
- Register 0:
  - reads always return 0, with rd_ready=1;
  - writes and allocs to index 0 are discarded;
  - busy[0] is always 0.
- Write (RUN): at posedge, for each i with wr_en[i] and wr_addr[i]!=0, rf[wr_addr[i]]<=wr_data[i]. If several ports hit the same address, the highest index i wins.
- Read (RUN), combinational, evaluated per port p:
  - rd_addr==0 → 0;
  - else if any enabled write port matches rd_addr → wr_data of the highest matching port (bypass);
  - else rf[rd_addr].
- rd_ready[p] = (rd_addr[p]==0) || bypass hit || !busy[rd_addr[p]].
- Scoreboard update at posedge (RUN), in priority order:
  1. flush: busy<=0; a same-cycle alloc is dropped.
  2. A matching enabled write clears busy[wr_addr].
  3. alloc_en sets busy[alloc_addr]. If alloc and a write clear hit the same address in one cycle, alloc wins (the new producer keeps the register busy).
- No backpressure. Writes to a non-busy register are legal and update data.
- busy_vec reflects registered state only; it shows no same-cycle bypass effect.

Decomposition:
- Shared package cpuDefine (alongside Gr/DType): regfile_state_e {INIT, RUN} and the default REG_NUM/DATA_W constants.
- One natural sub-module: regfile_bypass_mux. One instance per read port; it takes rd_addr, all write ports and the array word, and returns data plus a hit flag. Priority is the highest-index write port.
- Scoreboard and FSM stay in the top module.

Test Plan:
1. Release reset, REG_NUM=32 → init_done rises exactly 31 edges later. Every register then reads 0, and all rd_ready=1.
2. Same cycle wr_en=2'b11, wr_addr={5,5}, wr_data={0xBBBB,0xAAAA}, port 1 = 0xBBBB → rd_addr=5 shows 0xBBBB that cycle via bypass and from the array the next cycle.
3. alloc reg 7; next cycle read 7 → rd_ready=0. Write 7=0x1234 → rd_ready=1 and data 0x1234 in the write cycle; busy[7]=0 afterwards.
4. Same cycle alloc 9 and write 9 → busy[9]=1 next cycle. Flush with alloc 3 → busy_vec=0 next cycle.
5. Write reg 0 = 0xFFFF and alloc 0 → reg 0 reads 0, rd_ready=1, busy[0]=0.
6. Write reg 4=0x55 and wait. Assert areset mid-run for one cycle. Writes during INIT are ignored, and after init_done reg 4 reads 0.
